// File: rtl/cpu_core_param.sv
// Multicycle CPU core with a parametrised register file, a zero flag and a
// FETCH/EXEC/MEM/HALT sequencer talking to memory over a req/ack handshake.
module cpu_core_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREGS = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic                                   mem_req,
  output logic                                   mem_we,
  output logic [ADDR_W-1:0]                      mem_addr,
  output logic [DATA_W-1:0]                      mem_wdata,
  input  logic                                   mem_ack,
  // At least 32 bits wide so a full instruction word fits even when DATA_W is 16.
  input  logic [((DATA_W < 32) ? 32 : DATA_W)-1:0] mem_rdata,
  output logic                                   halted,
  output logic [1:0]                             state_o
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_LDI  = 6'd5;
  localparam logic [5:0] OP_LD   = 6'd6;
  localparam logic [5:0] OP_ST   = 6'd7;
  localparam logic [5:0] OP_JMP  = 6'd8;
  localparam logic [5:0] OP_BZ   = 6'd9;
  localparam logic [5:0] OP_CMP  = 6'd10;
  localparam logic [5:0] OP_HALT = 6'd11;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic              z;
  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0]        op;
  logic [RIDX_W-1:0] ra_i, rb_i, rd_i;
  logic [DATA_W-1:0] ra_val, rb_val, imm_sext, ea, alu_res, ld_data;
  logic [ADDR_W-1:0] jmp_tgt;

  assign op       = ir[5:0];
  assign ra_i     = ir[6 +: RIDX_W];
  assign rb_i     = ir[9 +: RIDX_W];
  assign rd_i     = ir[12 +: RIDX_W];
  assign ra_val   = regs[ra_i];
  assign rb_val   = regs[rb_i];
  assign imm_sext = DATA_W'($signed(ir[31:16]));
  assign jmp_tgt  = ADDR_W'(ir[31:16]);
  assign ea       = ra_val + imm_sext;
  assign ld_data  = mem_rdata[DATA_W-1:0];

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = ra_val + rb_val;
      OP_SUB:  alu_res = ra_val - rb_val;
      OP_AND:  alu_res = ra_val & rb_val;
      OP_OR:   alu_res = ra_val | rb_val;
      OP_XOR:  alu_res = ra_val ^ rb_val;
      default: alu_res = '0;
    endcase
  end

  // NOTE: non-blocking assignments throughout, so every read in EXEC sees the
  // pre-edge register values (ra==rd uses the old value as the operand).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      z         <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      // NOTE: the register file is small and architecturally cleared on reset,
      // so it is reset explicitly rather than left to power-up contents.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata[31:0];
            pc      <= pc + 1'b1;
            mem_req <= 1'b0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              regs[rd_i] <= alu_res;
              z          <= (alu_res == '0);
            end
            OP_LDI: regs[rd_i] <= imm_sext;
            OP_CMP: z <= (ra_val == rb_val);
            OP_JMP: pc <= jmp_tgt;
            OP_BZ:  if (z) pc <= jmp_tgt;
            OP_LD, OP_ST: begin
              mem_addr  <= ADDR_W'(ea);
              mem_we    <= (op == OP_ST);
              mem_wdata <= rb_val;
              state     <= S_MEM;
            end
            OP_HALT: state <= S_HALT;
            default: ;
          endcase
        end
        S_MEM: begin
          // Request rises one cycle after address setup, then waits for ack.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            if (!mem_we) regs[rd_i] <= ld_data;
            mem_req <= 1'b0;
            state   <= S_FETCH;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

  assign halted  = (state == S_HALT);
  assign state_o = state;

  // Reserved/ignored instruction bits and unused read-data bits.
  logic unused_bits;
  assign unused_bits = ^{ir, mem_rdata};

endmodule
